// File: rtl/aer_out_arbiter_if.sv
// ---------------------------------------------------------------------------
// aer_out_arbiter_if
// Bundles the spike-FIFO read side and the AER pad handshake of aer_out_arbiter.
//   FIFO_empty_i   per-source empty flags              (FIFOs   -> arbiter)
//   FIFO_r_en_o    per-source pop strobe, one-hot/zero (arbiter -> FIFOs)
//   FIFO_r_data_i  source k data at [k*M +: M]         (FIFOs   -> arbiter)
//   AER_ADDR_o     {src_idx[1:0], neuron_addr}         (arbiter -> pads)
//   AER_REQ_o      4-phase request                     (arbiter -> pads)
//   AER_ACK_i      4-phase acknowledge, pre-synced     (pads    -> arbiter)
// master = arbiter side, slave = FIFO/pad side.
// ---------------------------------------------------------------------------
interface aer_out_arbiter_if #(
    parameter int M    = 8,
    parameter int NSRC = 4
);
    logic [NSRC-1:0]   FIFO_empty_i;
    logic [NSRC-1:0]   FIFO_r_en_o;
    logic [NSRC*M-1:0] FIFO_r_data_i;
    logic [M+1:0]      AER_ADDR_o;
    logic              AER_REQ_o;
    logic              AER_ACK_i;

    modport master (
        input  FIFO_empty_i, FIFO_r_data_i, AER_ACK_i,
        output FIFO_r_en_o, AER_ADDR_o, AER_REQ_o
    );

    modport slave (
        output FIFO_empty_i, FIFO_r_data_i, AER_ACK_i,
        input  FIFO_r_en_o, AER_ADDR_o, AER_REQ_o
    );
endinterface

// File: rtl/aer_out_arbiter.sv
// ---------------------------------------------------------------------------
// aer_out_arbiter
// Round-robin scheduler sharing one AER output port between NSRC spike FIFOs.
// Pops one neuron address from the granted FIFO, prefixes the 2-bit source
// index and runs a 4-phase REQ/ACK handshake towards the off-chip receiver.
// Ports:
//   CLK            clock, posedge
//   RSTN           synchronous active-low reset
//   enable_i       allows new arbitration rounds
//   LIF_busy_i     LIF update in progress, blocks new rounds
//   clr_err_i      clears timeout_err_o (a same-cycle new timeout wins)
//   bus            FIFO read side + AER handshake (master modport)
//   busy_o         high in every state except IDLE
//   timeout_err_o  sticky ACK-timeout flag
//   evt_cnt_o      completed handshakes, wraps
// All outputs are registered.
// ---------------------------------------------------------------------------
module aer_out_arbiter #(
    parameter int M           = 8,
    parameter int NSRC        = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 enable_i,
    input  logic                 LIF_busy_i,
    input  logic                 clr_err_i,
    aer_out_arbiter_if.master    bus,
    output logic                 busy_o,
    output logic                 timeout_err_o,
    output logic [15:0]          evt_cnt_o
);

    typedef enum logic [2:0] {IDLE, ARB, WAIT, LOAD, REQ, ACKL} state_t;

    state_t      state;
    logic [1:0]  rr_ptr;      // last granted source
    logic [15:0] timer;
    logic        drop;        // current event was abandoned on timeout

    // Sources padded to 4 so a 2-bit index is always in range.
    logic [3:0]   not_empty;
    logic [M-1:0] src_data [4];

    assign not_empty = 4'(~bus.FIFO_empty_i);

    for (genvar k = 0; k < 4; k++) begin : g_src
        if (k < NSRC) begin : g_used
            assign src_data[k] = bus.FIFO_r_data_i[k*M +: M];
        end else begin : g_pad
            assign src_data[k] = '0;
        end
    end

    // Round-robin scan: rr_ptr+1, rr_ptr+2, ... mod NSRC; first non-empty wins.
    logic [1:0] gnt;
    logic       gnt_vld;
    logic [3:0] gnt_oh;

    always_comb begin : scan
        logic [1:0] idx;
        idx     = '0;
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int i = 1; i <= NSRC; i++) begin
            idx = 2'((int'(rr_ptr) + i) % NSRC);
            if (!gnt_vld && not_empty[idx]) begin
                gnt     = idx;
                gnt_vld = 1'b1;
            end
        end
    end

    assign gnt_oh = 4'b0001 << gnt;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state           <= IDLE;
            bus.FIFO_r_en_o <= '0;
            bus.AER_ADDR_o  <= '0;
            bus.AER_REQ_o   <= 1'b0;
            busy_o          <= 1'b0;
            timeout_err_o   <= 1'b0;
            evt_cnt_o       <= '0;
            rr_ptr          <= 2'(NSRC-1);
            timer           <= '0;
            drop            <= 1'b0;
        end else begin
            // Placed before the FSM so a timeout set below overrides the clear.
            if (clr_err_i) timeout_err_o <= 1'b0;

            case (state)
                IDLE: begin
                    // A stale ACK still high from the receiver blocks a new start.
                    if (enable_i && !LIF_busy_i && (|not_empty) && !bus.AER_ACK_i) begin
                        state  <= ARB;
                        busy_o <= 1'b1;
                    end
                end
                ARB: begin
                    if (gnt_vld) begin
                        bus.FIFO_r_en_o <= gnt_oh[NSRC-1:0];
                        rr_ptr          <= gnt;
                        state           <= WAIT;
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                WAIT: begin
                    // Pop strobe is visible to the FIFO this cycle; data follows next cycle.
                    bus.FIFO_r_en_o <= '0;
                    state           <= LOAD;
                end
                LOAD: begin
                    bus.AER_ADDR_o <= {rr_ptr, src_data[rr_ptr]};
                    bus.AER_REQ_o  <= 1'b1;
                    timer          <= '0;
                    state          <= REQ;
                end
                REQ: begin
                    if (bus.AER_ACK_i) begin
                        bus.AER_REQ_o <= 1'b0;
                        state         <= ACKL;
                    end else if (timer == 16'(ACK_TIMEOUT-1)) begin
                        // REQ has now been high for ACK_TIMEOUT cycles.
                        bus.AER_REQ_o <= 1'b0;
                        timeout_err_o <= 1'b1;
                        drop          <= 1'b1;
                        state         <= ACKL;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                ACKL: begin
                    if (!bus.AER_ACK_i) begin
                        if (!drop) evt_cnt_o <= evt_cnt_o + 16'd1;
                        drop   <= 1'b0;
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
